// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core with on-chip instruction/data memory and register file.
// Latency: one instruction retires per rising clk edge; fetch, decode, execute and memory read are combinational.
// Backpressure: none; there is no external bus and the core never stalls.
//
// Ports:
//   clk   - core clock; pc, register file and data memory update on the rising edge
//   reset - asynchronous, active-low; low forces pc=RESET_PC, clears x0..x31 and feeds a NOP to decode

// rv32i_mem: word-organised memory with combinational read and byte-strobed synchronous write.
// Latency: read data is combinational; writes land on the rising clk edge.
// Backpressure: none.
// Ports: clk; addr (word index); rdata; we; wstrb (byte lanes); wdata.
module rv32i_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata
);
    logic [31:0] mem [0:MEM_WORDS-1];

    assign rdata = mem[addr];

    // Byte/half stores only touch their own lanes, which is the read-modify-write of the word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// rv32i_regfile: 32x32 register file, two combinational read ports, one synchronous write port.
// Latency: reads combinational; write visible after the rising clk edge.
// Backpressure: none.
// Ports: clk; reset (async active-low, clears all); rs1_addr/rs1_data; rs2_addr/rs2_data; we/rd_addr/rd_data.
module rv32i_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    logic [31:0] regFile [0:31];

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regFile[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regFile[rs2_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= 32'h0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            regFile[rd_addr] <= rd_data;
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam int          AW  = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        sel_pc_a;   // operand A is pc instead of rs1
        logic        use_imm;    // operand B is the immediate instead of rs2
        logic [31:0] imm;
        logic        reg_we;
        logic        mem_we;
        logic        is_load;
        logic        is_link;    // rd receives pc+4
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
    } ctrl_t;

    logic [31:0] pc;
    logic [31:0] pc_in;
    logic [31:0] pc_plus4;
    logic [31:0] insn_word;
    logic [31:0] instruction_mux_out;
    logic [31:0] mux_a_out;
    logic [31:0] mux_b_out;
    logic [31:0] alu_out;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rd_data;
    logic [31:0] dmem_rdata;
    logic [31:0] load_shift;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic        branch_taken;
    ctrl_t       ctrl;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [1:0]  byte_off;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // ---------------- fetch ----------------
    rv32i_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) insn_memory (
        .clk   (clk),
        .addr  (pc[AW+1:2]),
        .rdata (insn_word),
        .we    (1'b0),
        .wstrb (4'b0000),
        .wdata (32'h0)
    );

    // Decode sees a NOP for as long as reset is held, so nothing can be written.
    assign instruction_mux_out = reset ? insn_word : NOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_in;
        end
    end

    // ---------------- decode ----------------
    assign opcode   = instruction_mux_out[6:0];
    assign rd_addr  = instruction_mux_out[11:7];
    assign funct3   = instruction_mux_out[14:12];
    assign rs1_addr = instruction_mux_out[19:15];
    assign rs2_addr = instruction_mux_out[24:20];

    assign imm_i = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
    assign imm_s = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25], instruction_mux_out[11:7]};
    assign imm_b = {{19{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[7],
                    instruction_mux_out[30:25], instruction_mux_out[11:8], 1'b0};
    assign imm_u = {instruction_mux_out[31:12], 12'h000};
    assign imm_j = {{11{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[19:12],
                    instruction_mux_out[20], instruction_mux_out[30:21], 1'b0};

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        ctrl.imm    = imm_i;
        case (opcode)
            OPC_LUI: begin
                ctrl.alu_op  = ALU_PASSB;
                ctrl.imm     = imm_u;
                ctrl.use_imm = 1'b1;
                ctrl.reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.sel_pc_a = 1'b1;
                ctrl.imm      = imm_u;
                ctrl.use_imm  = 1'b1;
                ctrl.reg_we   = 1'b1;
            end
            OPC_JAL: begin
                ctrl.sel_pc_a = 1'b1;
                ctrl.imm      = imm_j;
                ctrl.use_imm  = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.is_link  = 1'b1;
                ctrl.is_jal   = 1'b1;
            end
            OPC_JALR: begin
                ctrl.use_imm = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.is_link = 1'b1;
                ctrl.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                // The ALU forms the target pc+imm_b; rs1/rs2 go to the comparator.
                ctrl.sel_pc_a  = 1'b1;
                ctrl.imm       = imm_b;
                ctrl.use_imm   = 1'b1;
                ctrl.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.use_imm = 1'b1;
                ctrl.is_load = 1'b1;
                ctrl.reg_we  = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            OPC_STORE: begin
                ctrl.imm     = imm_s;
                ctrl.use_imm = 1'b1;
                ctrl.mem_we  = (funct3 inside {3'd0, 3'd1, 3'd2});
            end
            OPC_OPIMM: begin
                // Only the shift-right encoding uses bit 30; ADDI with a negative immediate must stay an add.
                ctrl.alu_op  = alu_sel(funct3, (funct3 == 3'd5) && instruction_mux_out[30]);
                ctrl.use_imm = 1'b1;
                ctrl.reg_we  = 1'b1;
            end
            OPC_OP: begin
                ctrl.alu_op = alu_sel(funct3, instruction_mux_out[30]);
                ctrl.reg_we = 1'b1;
            end
            default: ;  // FENCE, SYSTEM, all-zero and unknown words retire as NOPs
        endcase
    end

    rv32i_regfile register_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .we       (ctrl.reg_we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // ---------------- execute ----------------
    assign mux_a_out = ctrl.sel_pc_a ? pc : rs1_data;
    assign mux_b_out = ctrl.use_imm ? ctrl.imm : rs2_data;

    always_comb begin
        alu_out = 32'h0;
        case (ctrl.alu_op)
            ALU_ADD:   alu_out = mux_a_out + mux_b_out;
            ALU_SUB:   alu_out = mux_a_out - mux_b_out;
            ALU_SLL:   alu_out = mux_a_out << mux_b_out[4:0];
            ALU_SLT:   alu_out = {31'h0, $signed(mux_a_out) < $signed(mux_b_out)};
            ALU_SLTU:  alu_out = {31'h0, mux_a_out < mux_b_out};
            ALU_XOR:   alu_out = mux_a_out ^ mux_b_out;
            ALU_SRL:   alu_out = mux_a_out >> mux_b_out[4:0];
            ALU_SRA:   alu_out = 32'($signed(mux_a_out) >>> mux_b_out[4:0]);
            ALU_OR:    alu_out = mux_a_out | mux_b_out;
            ALU_AND:   alu_out = mux_a_out & mux_b_out;
            ALU_PASSB: alu_out = mux_b_out;
            default:   alu_out = mux_a_out + mux_b_out;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    branch_taken = (rs1_data == rs2_data);
            3'd1:    branch_taken = (rs1_data != rs2_data);
            3'd4:    branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'd5:    branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    branch_taken = (rs1_data <  rs2_data);
            3'd7:    branch_taken = (rs1_data >= rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_in = pc_plus4;
        if (ctrl.is_jal || (ctrl.is_branch && branch_taken)) begin
            pc_in = alu_out;
        end else if (ctrl.is_jalr) begin
            pc_in = alu_out & ~32'h1;
        end
    end

    // ---------------- memory ----------------
    assign byte_off = alu_out[1:0];

    always_comb begin
        case (funct3)
            3'd0:    store_strb = 4'b0001 << byte_off;
            3'd1:    store_strb = 4'b0011 << byte_off;
            default: store_strb = 4'b1111;
        endcase
        store_data = (funct3 == 3'd2) ? rs2_data : (rs2_data << {byte_off, 3'b000});
    end

    rv32i_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) data_memory (
        .clk   (clk),
        .addr  (alu_out[AW+1:2]),
        .rdata (dmem_rdata),
        .we    (ctrl.mem_we),
        .wstrb (store_strb),
        .wdata (store_data)
    );

    // Sub-word loads shift the addressed lane down to bit 0 before extension.
    assign load_shift = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (funct3)
            3'd0:    load_data = {{24{load_shift[7]}}, load_shift[7:0]};
            3'd1:    load_data = {{16{load_shift[15]}}, load_shift[15:0]};
            3'd4:    load_data = {24'h0, load_shift[7:0]};
            3'd5:    load_data = {16'h0, load_shift[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // ---------------- writeback ----------------
    assign rd_data = ctrl.is_load ? load_data : (ctrl.is_link ? pc_plus4 : alu_out);
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed-program bench for rv32i_core.
// Latency: checks sample #1 after each rising edge, so every retired instruction is visible.
// Backpressure: none; programs run for fixed cycle counts.
module tb_rv32i_core;
    logic clk;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] prog [$];

    rv32i_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Hold reset, clear both memories and load prog into instruction memory.
    task automatic load_prog();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut.insn_memory.mem[i] <= (i < prog.size()) ? prog[i] : 32'h0;
            dut.data_memory.mem[i] <= 32'h0;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rf(input int idx);
        return dut.register_file.regFile[idx];
    endfunction

    // Control program: counted BNE loop, BEQ taken/not taken, JAL/JALR.
    task automatic set_ctrl_prog();
        prog = '{
            addi(1, 0, 0),              // 0x00
            addi(2, 0, 10),             // 0x04
            addi(1, 1, 1),              // 0x08 loop body
            enc_b(-4, 2, 1, 1),         // 0x0C BNE x1,x2,-4
            enc_b(8, 2, 1, 0),          // 0x10 BEQ x1,x2,+8 (taken)
            addi(5, 0, 1),              // 0x14 skipped
            enc_b(8, 0, 1, 0),          // 0x18 BEQ x1,x0,+8 (not taken)
            addi(6, 0, 1),              // 0x1C
            enc_j(8, 1),                // 0x20 JAL x1,+8
            addi(7, 0, 7),              // 0x24
            enc_i(0, 1, 0, 0, 7'b1100111) // 0x28 JALR x0,0(x1)
        };
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;

        // ---------------- reset + ALU program ----------------
        prog = '{
            addi(1, 0, 5),
            addi(2, 0, -3),
            enc_r(7'h00, 2, 1, 0, 3),   // ADD  x3,x1,x2
            enc_r(7'h20, 2, 1, 0, 4),   // SUB  x4,x1,x2
            enc_r(7'h00, 1, 2, 2, 5),   // SLT  x5,x2,x1
            enc_r(7'h00, 1, 2, 3, 6),   // SLTU x6,x2,x1
            enc_i(32'h401, 2, 5, 7, 7'b0010011) // SRAI x7,x2,1
        };
        for (int i = 0; i < 1024; i++) begin
            dut.insn_memory.mem[i] <= (i < prog.size()) ? prog[i] : 32'h0;
            dut.data_memory.mem[i] <= 32'h0;
        end
        #6;
        check("reset_pc", dut.pc, 32'h0);
        check("reset_x1", rf(1), 32'h0);
        check("reset_x31", rf(31), 32'h0);
        check("reset_insn_nop", dut.instruction_mux_out, 32'h0000_0013);
        release_reset();
        #1;
        check("first_fetch", dut.instruction_mux_out, prog[0]);
        step(1);
        check("pc_after_first", dut.pc, 32'h4);
        step(6);
        check("alu_x1", rf(1), 32'h0000_0005);
        check("alu_x2", rf(2), 32'hFFFF_FFFD);
        check("alu_x3_add", rf(3), 32'h0000_0002);
        check("alu_x4_sub", rf(4), 32'h0000_0008);
        check("alu_x5_slt", rf(5), 32'h0000_0001);
        check("alu_x6_sltu", rf(6), 32'h0000_0000);
        check("alu_x7_srai", rf(7), 32'hFFFF_FFFE);

        // ---------------- memory program ----------------
        prog = '{
            enc_i(260, 0, 2, 1, 7'b0000011),  // LW x1,260(x0)
            enc_i(264, 0, 2, 2, 7'b0000011),  // LW x2,264(x0)
            enc_r(7'h00, 2, 1, 0, 3),         // ADD x3,x1,x2
            enc_s(268, 3, 0, 2),              // SW x3,268(x0)
            enc_s(269, 1, 0, 0),              // SB x1,269(x0)
            addi(9, 0, 128),
            enc_s(268, 9, 0, 0),              // SB x9,268(x0)
            enc_i(268, 0, 0, 8, 7'b0000011),  // LB  x8,268(x0)
            enc_i(268, 0, 4, 10, 7'b0000011), // LBU x10,268(x0)
            enc_i(268, 0, 1, 11, 7'b0000011)  // LH  x11,268(x0)
        };
        load_prog();
        dut.data_memory.mem[65] <= 32'd7;
        dut.data_memory.mem[66] <= 32'd2;
        #1;
        release_reset();
        step(4);
        check("mem_x3", rf(3), 32'h0000_0009);
        check("mem_sw", dut.data_memory.mem[67], 32'h0000_0009);
        step(1);
        check("mem_sb_lane1", dut.data_memory.mem[67], 32'h0000_0709);
        step(2);
        check("mem_sb_lane0", dut.data_memory.mem[67], 32'h0000_0780);
        step(3);
        check("mem_lb", rf(8), 32'hFFFF_FF80);
        check("mem_lbu", rf(10), 32'h0000_0080);
        check("mem_lh", rf(11), 32'h0000_0780);

        // ---------------- control program ----------------
        set_ctrl_prog();
        load_prog();
        release_reset();
        step(22);
        check("loop_exit_pc", dut.pc, 32'h10);
        check("loop_exit_x1", rf(1), 32'd10);
        step(1);
        check("beq_taken_pc", dut.pc, 32'h18);
        step(1);
        check("beq_not_taken_pc", dut.pc, 32'h1C);
        step(2);
        check("jal_pc", dut.pc, 32'h28);
        check("jal_link", rf(1), 32'h24);
        step(1);
        check("jalr_pc", dut.pc, 32'h24);
        step(1);
        check("ret_x7", rf(7), 32'd7);
        check("skip_x5", rf(5), 32'd0);
        check("fall_x6", rf(6), 32'd1);

        // ---------------- x0, upper immediates, more branches ----------------
        prog = '{
            addi(0, 0, 1),                    // 0x00 ADDI x0,x0,1
            enc_u(32'h12345, 1, 7'b0110111),  // 0x04 LUI x1
            enc_u(1, 2, 7'b0010111),          // 0x08 AUIPC x2,1
            addi(3, 0, -1),                   // 0x0C
            enc_b(8, 0, 3, 4),                // 0x10 BLT x3,x0,+8 (taken)
            addi(4, 0, 1),                    // 0x14 skipped
            enc_b(8, 0, 3, 6),                // 0x18 BLTU x3,x0,+8 (not taken)
            addi(5, 0, 1),                    // 0x1C
            enc_b(8, 0, 3, 7),                // 0x20 BGEU x3,x0,+8 (taken)
            addi(6, 0, 1),                    // 0x24 skipped
            enc_i(28, 3, 5, 7, 7'b0010011),   // 0x28 SRLI x7,x3,28
            enc_i(-1, 1, 4, 8, 7'b0010011)    // 0x2C XORI x8,x1,-1
        };
        load_prog();
        release_reset();
        step(10);
        check("x0_zero", rf(0), 32'h0);
        check("lui_x1", rf(1), 32'h1234_5000);
        check("auipc_x2", rf(2), 32'h0000_1008);
        check("blt_skip_x4", rf(4), 32'h0);
        check("bltu_fall_x5", rf(5), 32'h1);
        check("bgeu_skip_x6", rf(6), 32'h0);
        check("srli_x7", rf(7), 32'h0000_000F);
        check("xori_x8", rf(8), 32'hEDCB_AFFF);
        check("end_pc", dut.pc, 32'h30);

        // ---------------- asynchronous reset mid-run ----------------
        set_ctrl_prog();
        load_prog();
        release_reset();
        step(20);
        check("pre_reset_x1", rf(1), 32'd9);
        #3 reset = 1'b0;
        #1;
        check("async_pc", dut.pc, 32'h0);
        check("async_x1", rf(1), 32'h0);
        check("async_x2", rf(2), 32'h0);
        check("async_insn_nop", dut.instruction_mux_out, 32'h0000_0013);
        release_reset();
        step(28);
        check("rerun_x1", rf(1), 32'h24);
        check("rerun_x7", rf(7), 32'd7);
        check("rerun_pc", dut.pc, 32'h28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
